// File: rtl/hilo_if.sv
// Request/result bundle between the pipeline and the Hi/Lo unit.
// The pipeline issues a request; the unit returns Hi/Lo, Busy and Done.
interface hilo_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [5:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Hi_out;
    logic [WIDTH-1:0] Lo_out;
    logic             Busy;
    logic             Done;

    modport master (output Start, Op, A, B, input Hi_out, Lo_out, Busy, Done);
    modport slave  (input Start, Op, A, B, output Hi_out, Lo_out, Busy, Done);
endinterface

// File: rtl/hilo_unit.sv
// Architectural Hi/Lo register pair with an iterative shift-add multiplier
// for mult/multu/madd/msub, plus single-cycle mthi/mtlo.
//
// state | meaning
// IDLE  | accepting Start; mthi/mtlo complete here
// MUL   | one shift-add step per cycle, WIDTH steps
// FIN   | sign-correct product and write Hi/Lo
module hilo_unit #(
    parameter int WIDTH = 32
) (
    input logic   Clk,
    input logic   Rst,
    hilo_if.slave bus
);
    localparam logic [5:0] OP_MULT  = 6'b000110;
    localparam logic [5:0] OP_MULTU = 6'b000111;
    localparam logic [5:0] OP_MADD  = 6'b001000;
    localparam logic [5:0] OP_MSUB  = 6'b001001;
    localparam logic [5:0] OP_MTHI  = 6'b010000;
    localparam logic [5:0] OP_MTLO  = 6'b010001;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

    state_t               state, state_nxt;
    logic [2*WIDTH-1:0]   acc, mcand, product_p, hilo_new;
    logic [WIDTH-1:0]     mplier, hi_q, lo_q, mag_a, mag_b;
    logic [5:0]           op_q;
    logic [CW-1:0]        cnt;
    logic                 sign_q, done_q, is_mul, is_signed, last_step;

    always_comb begin
        is_mul    = (bus.Op == OP_MULT) || (bus.Op == OP_MULTU) ||
                    (bus.Op == OP_MADD) || (bus.Op == OP_MSUB);
        is_signed = (bus.Op != OP_MULTU);
        mag_a     = (is_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
        mag_b     = (is_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;
        last_step = (cnt == CW'(WIDTH - 1));
        product_p = sign_q ? -acc : acc;
        case (op_q)
            OP_MADD: hilo_new = {hi_q, lo_q} + product_p;
            OP_MSUB: hilo_new = {hi_q, lo_q} - product_p;
            default: hilo_new = product_p;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.Start && is_mul) state_nxt = MUL;
            MUL:     if (last_step) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            op_q   <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        if (bus.Op == OP_MTHI) begin
                            hi_q   <= bus.A;
                            done_q <= 1'b1;
                        end else if (bus.Op == OP_MTLO) begin
                            lo_q   <= bus.A;
                            done_q <= 1'b1;
                        end else if (is_mul) begin
                            mcand  <= {{WIDTH{1'b0}}, mag_a};
                            mplier <= mag_b;
                            sign_q <= is_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                            op_q   <= bus.Op;
                            acc    <= '0;
                            cnt    <= '0;
                        end
                    end
                end
                MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                FIN: begin
                    {hi_q, lo_q} <= hilo_new;
                    done_q       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.Hi_out = hi_q;
    assign bus.Lo_out = lo_q;
    assign bus.Busy   = (state != IDLE);
    assign bus.Done   = done_q;
endmodule
